// File: rtl/clk_freq_meter_pkg.sv
// Shared types for the gated-window frequency meter.
// Keeps the FSM encoding in one place so the top and any future siblings agree on it.
package clk_freq_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a one-cycle rising-edge pulse.
// Reusable for buttons and other asynchronous inputs.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s_meta;
    logic s_sync;
    logic s_dly;

    // s_meta may go metastable; only s_sync and s_dly are used as logic values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_dly  <= 1'b0;
        end else begin
            s_meta <= async_in;
            s_sync <= s_meta;
            s_dly  <= s_sync;
        end
    end

    assign rise = s_sync & ~s_dly;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated-window frequency meter: counts rising edges of i_sig over GATE_CYC i_clk cycles
// and reports the saturated count once per window with a one-cycle o_valid strobe.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned I_CLK_FRE = 100_000_000,
    parameter int unsigned GATE_CYC  = 100_000_000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_valid,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned      GATE_W    = $clog2(GATE_CYC);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // A window shorter than two cycles has no room for a gate phase plus report.
    if (GATE_CYC < 2) begin : g_bad_gate
        $error("clk_freq_meter: GATE_CYC must be >= 2");
    end
    if (I_CLK_FRE == 0) begin : g_bad_fre
        $error("clk_freq_meter: I_CLK_FRE must be non-zero");
    end

    state_t            state;
    state_t            state_nxt;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              inc_sat;
    logic              ovf_acc;
    logic              sig_rise;
    logic              last_cyc;

    sync_edge_det u_sync (
        .clk      (i_clk),
        .rst      (i_rst),
        .async_in (i_sig),
        .rise     (sig_rise)
    );

    assign last_cyc = (state == ST_GATE) && (gate_cnt == GATE_LAST);
    assign o_busy   = (state == ST_GATE);

    // Saturating increment shared by the running count and the final report.
    always_comb begin
        inc_sat = sig_rise && (edge_cnt == CNT_MAX);
        cnt_inc = edge_cnt;
        if (sig_rise && !inc_sat) begin
            cnt_inc = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping i_en leaves GATE whether mid-window (abort) or on the last cycle (after reporting).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_en) begin
                    state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                if (!i_en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            o_cnt    <= '0;
            o_ovf    <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state != ST_GATE) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_acc  <= 1'b0;
            end else if (last_cyc) begin
                // The edge seen on the last cycle belongs to this window, not the next one.
                o_cnt    <= cnt_inc;
                o_ovf    <= ovf_acc | inc_sat;
                o_valid  <= 1'b1;
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_acc  <= 1'b0;
            end else if (!i_en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_acc  <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= cnt_inc;
                ovf_acc  <= ovf_acc | inc_sat;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomised bench for clk_freq_meter with a window-level reference model.
// Two instances (32-bit and 4-bit counters) share the stimulus so saturation is covered too.
module tb_clk_freq_meter;

    localparam int GATE_CYC = 100;
    localparam int HIST     = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    logic        valid32, valid4, ovf32, ovf4, busy32, busy4;

    always #5 clk = ~clk;

    clk_freq_meter #(.I_CLK_FRE(100_000_000), .GATE_CYC(GATE_CYC), .CNT_W(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sig(sig),
        .o_cnt(cnt32), .o_valid(valid32), .o_ovf(ovf32), .o_busy(busy32)
    );

    clk_freq_meter #(.I_CLK_FRE(100_000_000), .GATE_CYC(GATE_CYC), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sig(sig),
        .o_cnt(cnt4), .o_valid(valid4), .o_ovf(ovf4), .o_busy(busy4)
    );

    int pass_count  = 0;
    int check_count = 0;

    // Sampled input history, indexed by rising-edge number of clk.
    bit sig_hist [HIST];
    bit en_hist  [HIST];
    bit rst_hist [HIST];
    int p_idx = 0;

    // Reference model state.
    bit      m_gate = 1'b0;
    int      m_start = 0;
    longint  exp_cnt32 = 0;
    longint  exp_cnt4 = 0;
    bit      exp_ovf32 = 1'b0;
    bit      exp_ovf4 = 1'b0;
    bit      exp_valid = 1'b0;

    // Stimulus generator: 0 hold low, 1 hold high, 2 fixed period, 3 random dwell.
    int sig_mode = 1;
    int sig_per  = 10;
    int dwell    = 1;
    bit rst_release = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", tag, actual, expected, p_idx, $time);
        end
    endtask

    // An edge sampled at clock n is a rise if the previous sample was low or cleared by reset.
    function automatic int riseAt(input int n);
        if (n < 1) return 0;
        if (sig_hist[n] && !rst_hist[n] && (!sig_hist[n-1] || rst_hist[n-1])) return 1;
        return 0;
    endfunction

    // A rise first sampled at clock n is counted at clock n+2 by the 3-cycle input path.
    function automatic longint risesCountedIn(input int first_edge, input int last_edge);
        longint total = 0;
        for (int n = first_edge - 2; n <= last_edge - 2; n++) total += riseAt(n);
        return total;
    endfunction

    task automatic modelEdge();
        longint total;
        exp_valid = 1'b0;
        if (rst_hist[p_idx]) begin
            m_gate    = 1'b0;
            exp_cnt32 = 0;
            exp_cnt4  = 0;
            exp_ovf32 = 1'b0;
            exp_ovf4  = 1'b0;
        end else if (!m_gate) begin
            if (en_hist[p_idx]) begin
                m_gate  = 1'b1;
                m_start = p_idx + 1;
            end
        end else if (p_idx - m_start == GATE_CYC - 1) begin
            total     = risesCountedIn(m_start, p_idx);
            exp_cnt32 = (total > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : total;
            exp_ovf32 = (total > 64'hFFFF_FFFF);
            exp_cnt4  = (total > 15) ? 15 : total;
            exp_ovf4  = (total > 15);
            exp_valid = 1'b1;
            if (en_hist[p_idx]) m_start = p_idx + 1;
            else                m_gate  = 1'b0;
        end else if (!en_hist[p_idx]) begin
            m_gate = 1'b0;
        end
    endtask

    task automatic nextSig();
        case (sig_mode)
            0: sig = 1'b0;
            1: sig = 1'b1;
            default: begin
                if (dwell <= 1) begin
                    sig = ~sig;
                    if (sig_mode == 2) dwell = sig ? sig_per / 2 : sig_per - sig_per / 2;
                    else               dwell = $urandom_range(1, 6);
                end else begin
                    dwell--;
                end
            end
        endcase
    endtask

    // One clock: drive at negedge, record at posedge, compare 1 time unit later.
    task automatic applyStimulus();
        @(negedge clk);
        if (rst_release) begin
            rst = 1'b0;
            rst_release = 1'b0;
        end
        nextSig();
        @(posedge clk);
        p_idx++;
        if (p_idx >= HIST) begin
            $display("[TB] FAIL hist_overflow: got %0d, expected < %0d", p_idx, HIST);
            $fatal(1, "[TB] history exhausted");
        end
        sig_hist[p_idx] = sig;
        en_hist[p_idx]  = en;
        rst_hist[p_idx] = rst;
        #1;
        modelEdge();
        checkOutput("busy32",  busy32,  m_gate);
        checkOutput("busy4",   busy4,   m_gate);
        checkOutput("valid32", valid32, exp_valid);
        checkOutput("valid4",  valid4,  exp_valid);
        checkOutput("cnt32",   cnt32,   exp_cnt32);
        checkOutput("cnt4",    cnt4,    exp_cnt4);
        checkOutput("ovf32",   ovf32,   exp_ovf32);
        checkOutput("ovf4",    ovf4,    exp_ovf4);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!valid32 && n < budget);
        if (!valid32) checkOutput("valid_timeout", valid32, 1);
    endtask

    // Step until the next clock edge will be gate cycle `pos` of the current window.
    task automatic waitGatePos(input int pos, input int budget);
        int n = 0;
        while (!(m_gate && (p_idx - m_start == pos - 1)) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (n >= budget) checkOutput("gatepos_timeout", n, 0);
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_cnt32", cnt32, 0);
        checkOutput("rst_valid", valid32, 0);
        checkOutput("rst_ovf",   ovf32, 0);
        checkOutput("rst_busy",  busy32, 0);
        m_gate    = 1'b0;
        exp_valid = 1'b0;
        exp_cnt32 = 0;
        exp_cnt4  = 0;
        exp_ovf32 = 1'b0;
        exp_ovf4  = 1'b0;
        applyStimulus();
        rst_release = 1'b1;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        en  = 1'b0;
        sig = 1'b1;
        rst_hist[0] = 1'b1;
        $display("[TB] starting clk_freq_meter bench");

        runCycles(3);
        rst_release = 1'b1;
        runCycles(20);

        // i_sig high since before enable: no phantom edge in any window.
        en = 1'b1;
        waitValid(150);
        checkOutput("held_hi_cnt", cnt32, 0);
        waitValid(150);

        sig_mode = 0;
        waitValid(150);
        waitValid(150);
        checkOutput("held_lo_cnt", cnt32, 0);

        // Period 4 saturates the 4-bit instance.
        sig_mode = 2;
        sig_per  = 4;
        waitValid(150);
        waitValid(150);
        checkOutput("p4_cnt32", cnt32, 25);
        checkOutput("p4_cnt4",  cnt4,  15);
        checkOutput("p4_ovf4",  ovf4,  1);
        waitValid(150);

        sig_per = 10;
        waitValid(150);
        waitValid(150);
        checkOutput("p10_cnt32", cnt32, 10);
        checkOutput("p10_cnt4",  cnt4,  10);
        checkOutput("p10_ovf4",  ovf4,  0);

        // Abort at gate cycle 50, then re-enable and time the first report.
        sig_mode = 3;
        waitGatePos(50, 200);
        en = 1'b0;
        applyStimulus();
        checkOutput("abort_busy", busy32, 0);
        runCycles(15);
        en = 1'b1;
        k = p_idx + 1;
        waitValid(150);
        checkOutput("reen_latency", p_idx, k + GATE_CYC);
        waitValid(150);

        // i_en low on the last gate cycle still reports.
        waitGatePos(GATE_CYC - 1, 200);
        en = 1'b0;
        applyStimulus();
        checkOutput("lastcyc_valid", valid32, 1);
        checkOutput("lastcyc_busy",  busy32, 0);
        runCycles(5);

        // Asynchronous reset mid-window, then a clean restart.
        en = 1'b1;
        runCycles(40);
        pulseReset();
        waitValid(150);
        waitValid(150);
        runCycles(5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
